// File: rtl/or_window_accumulator_pkg.sv
// Shared definitions for the sticky-OR window accumulator.
// State encoding and counter width used by the accumulator core.
package or_window_accumulator_pkg;

    localparam int COUNT_WIDTH = 16;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_e;

endpackage

// File: rtl/or_window_accumulator.sv
// Sticky-OR accumulator: folds WindowLength accepted words into one
// word with bitwise OR and presents it on a valid/ready output.
module or_window_accumulator
    import or_window_accumulator_pkg::*;
#(
    parameter int                    NrOfBits     = 1,
    parameter int                    WindowLength = 4,
    parameter logic [NrOfBits-1:0]   InvertMask   = '0
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     tick,
    input  logic                     clear,
    input  logic [NrOfBits-1:0]      in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [NrOfBits-1:0]      out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [NrOfBits-1:0]      partial_data,
    output logic [COUNT_WIDTH-1:0]   sample_count
);

    localparam logic [COUNT_WIDTH-1:0] LAST_COUNT =
        COUNT_WIDTH'(WindowLength - 1);

    state_e                state;
    logic [NrOfBits-1:0]   nd;
    logic [NrOfBits-1:0]   folded;
    logic                  last;

    assign nd       = in_data ^ InvertMask;
    assign folded   = partial_data | nd;
    assign last     = (sample_count == LAST_COUNT);
    assign in_ready = (state == ACCUM) & ~clear;

    // HOLD ignores clear so a finished window is never lost.
    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= ACCUM;
            partial_data <= '0;
            sample_count <= '0;
            out_data     <= '0;
            out_valid    <= 1'b0;
        end else if (tick) begin
            unique case (state)
                ACCUM: begin
                    if (clear) begin
                        partial_data <= '0;
                        sample_count <= '0;
                    end else if (in_valid) begin
                        if (last) begin
                            out_data     <= folded;
                            out_valid    <= 1'b1;
                            partial_data <= '0;
                            sample_count <= '0;
                            state        <= HOLD;
                        end else begin
                            partial_data <= folded;
                            sample_count <= sample_count + 16'd1;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= ACCUM;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_or_window_accumulator.sv
// Bench for or_window_accumulator: cycle table, hand sequences and a
// scoreboard of completed windows on two parameterisations.
module tb_or_window_accumulator;

    logic        clock = 1'b0;
    logic        reset, tick, clear;
    logic [3:0]  in_data, out_data, partial_data;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [15:0] sample_count;

    logic [3:0]  d2, od2, p2;
    logic        v2, ir2, ov2, ordy2;
    logic [15:0] cnt2;

    int errors = 0;
    int checks = 0;
    logic        sb_on = 1'b0;
    logic [3:0]  sb_q[$];

    always #5 clock = ~clock;

    or_window_accumulator #(
        .NrOfBits(4), .WindowLength(4), .InvertMask(4'b0000)
    ) u_dut (
        .clock(clock), .reset(reset), .tick(tick), .clear(clear),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .partial_data(partial_data),
        .sample_count(sample_count)
    );

    or_window_accumulator #(
        .NrOfBits(4), .WindowLength(1), .InvertMask(4'b0101)
    ) u_inv (
        .clock(clock), .reset(reset), .tick(tick), .clear(clear),
        .in_data(d2), .in_valid(v2), .in_ready(ir2),
        .out_data(od2), .out_valid(ov2),
        .out_ready(ordy2), .partial_data(p2),
        .sample_count(cnt2)
    );

    typedef struct packed {
        logic        tick;
        logic        clear;
        logic        vld;
        logic [3:0]  d;
        logic        ordy;
        logic        e_ir;
        logic        e_ov;
        logic [3:0]  e_od;
        logic [3:0]  e_p;
        logic [15:0] e_c;
    } vec_t;

    vec_t tbl[14];

    task automatic chk(input string name, input logic [15:0] act,
                       input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Scoreboard: pop on every output handshake.
    always @(negedge clock) begin
        if (sb_on && !reset && tick && out_valid && out_ready) begin
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: got %h expected none",
                         out_data);
            end else begin
                logic [3:0] e;
                e = sb_q.pop_front();
                if (out_data !== e) begin
                    errors++;
                    $display("FAIL sb_data: got %h expected %h",
                             out_data, e);
                end
            end
        end
    end

    task automatic drive_window(input logic [3:0] w0, input logic [3:0] w1,
                                input logic [3:0] w2, input logic [3:0] w3);
        logic [3:0] ws[4];
        logic [3:0] acc;
        ws[0] = w0; ws[1] = w1; ws[2] = w2; ws[3] = w3;
        acc = '0;
        for (int k = 0; k < 4; k++) begin
            int  guard;
            bit  done;
            guard = 0;
            done  = 0;
            in_valid = 1'b1;
            in_data  = ws[k];
            while (!done) begin
                tick      = ($urandom_range(0, 3) != 0);
                out_ready = $urandom_range(0, 1);
                @(negedge clock);
                if (tick && in_ready) begin
                    acc = acc | ws[k];
                    if (k == 3) sb_q.push_back(acc);
                    done = 1;
                end
                step();
                guard++;
                if (!done && guard > 100) begin
                    chk("accept_timeout", 16'(guard), 16'd0);
                    done = 1;
                end
            end
            in_valid = 1'b0;
        end
    endtask

    initial begin
        tbl[0]  = '{1'b1,1'b0,1'b1,4'b0001,1'b0, 1'b1,1'b0,4'h0,4'h0,16'd0};
        tbl[1]  = '{1'b0,1'b0,1'b1,4'b0010,1'b1, 1'b1,1'b0,4'h0,4'h1,16'd1};
        tbl[2]  = '{1'b0,1'b0,1'b1,4'b0010,1'b1, 1'b1,1'b0,4'h0,4'h1,16'd1};
        tbl[3]  = '{1'b0,1'b0,1'b1,4'b0010,1'b1, 1'b1,1'b0,4'h0,4'h1,16'd1};
        tbl[4]  = '{1'b0,1'b0,1'b1,4'b0010,1'b1, 1'b1,1'b0,4'h0,4'h1,16'd1};
        tbl[5]  = '{1'b0,1'b0,1'b1,4'b0010,1'b1, 1'b1,1'b0,4'h0,4'h1,16'd1};
        tbl[6]  = '{1'b1,1'b0,1'b1,4'b0010,1'b0, 1'b1,1'b0,4'h0,4'h1,16'd1};
        tbl[7]  = '{1'b1,1'b0,1'b1,4'b0000,1'b0, 1'b1,1'b0,4'h0,4'h3,16'd2};
        tbl[8]  = '{1'b1,1'b0,1'b1,4'b1000,1'b0, 1'b1,1'b0,4'h0,4'h3,16'd3};
        tbl[9]  = '{1'b0,1'b0,1'b0,4'b0000,1'b1, 1'b0,1'b1,4'hb,4'h0,16'd0};
        tbl[10] = '{1'b0,1'b0,1'b0,4'b0000,1'b1, 1'b0,1'b1,4'hb,4'h0,16'd0};
        tbl[11] = '{1'b1,1'b1,1'b1,4'b0100,1'b0, 1'b0,1'b1,4'hb,4'h0,16'd0};
        tbl[12] = '{1'b1,1'b0,1'b0,4'b0000,1'b1, 1'b0,1'b1,4'hb,4'h0,16'd0};
        tbl[13] = '{1'b1,1'b0,1'b0,4'b0000,1'b0, 1'b1,1'b0,4'hb,4'h0,16'd0};

        reset = 1'b1; tick = 1'b0; clear = 1'b0;
        in_data = '0; in_valid = 1'b0; out_ready = 1'b0;
        d2 = '0; v2 = 1'b0; ordy2 = 1'b0;
        step();
        step();
        reset = 1'b0;
        tick  = 1'b1;
        @(negedge clock);
        chk("rst_out_valid", 16'(out_valid), 16'd0);
        chk("rst_out_data", 16'(out_data), 16'd0);
        chk("rst_partial", 16'(partial_data), 16'd0);
        chk("rst_count", sample_count, 16'd0);
        chk("rst_in_ready", 16'(in_ready), 16'd1);
        step();

        // Fold, tick gating and clear-in-HOLD, cycle by cycle.
        for (int i = 0; i < 14; i++) begin
            tick      = tbl[i].tick;
            clear     = tbl[i].clear;
            in_valid  = tbl[i].vld;
            in_data   = tbl[i].d;
            out_ready = tbl[i].ordy;
            @(negedge clock);
            chk($sformatf("tbl%0d_in_ready", i), 16'(in_ready), 16'(tbl[i].e_ir));
            chk($sformatf("tbl%0d_out_valid", i), 16'(out_valid), 16'(tbl[i].e_ov));
            chk($sformatf("tbl%0d_out_data", i), 16'(out_data), 16'(tbl[i].e_od));
            chk($sformatf("tbl%0d_partial", i), 16'(partial_data), 16'(tbl[i].e_p));
            chk($sformatf("tbl%0d_count", i), sample_count, tbl[i].e_c);
            step();
        end
        tick = 1'b1; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0;

        // Clear mid-window drops the partial fold and the word offered.
        in_valid = 1'b1; in_data = 4'b0001; step();
        in_data = 4'b0010; step();
        clear = 1'b1; in_data = 4'b1000;
        @(negedge clock);
        chk("clr_in_ready", 16'(in_ready), 16'd0);
        chk("clr_partial_before", 16'(partial_data), 16'h3);
        step();
        clear = 1'b0; in_valid = 1'b0;
        @(negedge clock);
        chk("clr_partial", 16'(partial_data), 16'd0);
        chk("clr_count", sample_count, 16'd0);
        step();
        sb_on = 1'b1;
        drive_window(4'b0100, 4'b0000, 4'b0000, 4'b0000);
        for (int n = 0; n < 6; n++)
            drive_window(4'($urandom), 4'($urandom),
                         4'($urandom), 4'($urandom));
        tick = 1'b1; out_ready = 1'b1;
        for (int g = 0; g < 20 && sb_q.size() != 0; g++) step();
        chk("sb_drained", 16'(sb_q.size()), 16'd0);
        step();
        sb_on = 1'b0; out_ready = 1'b0;

        // Inverted lanes with a single-word window.
        v2 = 1'b1; d2 = 4'b0101;
        @(negedge clock);
        chk("inv_in_ready", 16'(ir2), 16'd1);
        step();
        v2 = 1'b0;
        @(negedge clock);
        chk("inv0_valid", 16'(ov2), 16'd1);
        chk("inv0_data", 16'(od2), 16'h0);
        chk("inv0_in_ready", 16'(ir2), 16'd0);
        ordy2 = 1'b1; step();
        ordy2 = 1'b0;
        @(negedge clock);
        chk("inv_release", 16'(ov2), 16'd0);
        v2 = 1'b1; d2 = 4'b0000; step();
        v2 = 1'b0;
        @(negedge clock);
        chk("inv1_valid", 16'(ov2), 16'd1);
        chk("inv1_data", 16'(od2), 16'h5);
        ordy2 = 1'b1; step();
        ordy2 = 1'b0;

        // Reset in HOLD with tick low discards the pending result.
        out_ready = 1'b0; in_valid = 1'b1;
        in_data = 4'b0110; step();
        in_data = 4'b0001; step();
        in_data = 4'b0000; step();
        in_data = 4'b0000; step();
        in_valid = 1'b0;
        @(negedge clock);
        chk("hold_valid", 16'(out_valid), 16'd1);
        chk("hold_data", 16'(out_data), 16'h7);
        tick = 1'b0; reset = 1'b1; out_ready = 1'b1; step();
        reset = 1'b0; out_ready = 1'b0; tick = 1'b1;
        @(negedge clock);
        chk("rsth_valid", 16'(out_valid), 16'd0);
        chk("rsth_data", 16'(out_data), 16'd0);
        chk("rsth_in_ready", 16'(in_ready), 16'd1);
        step();

        // Reset mid-window beats clear and an offered word.
        in_valid = 1'b1; in_data = 4'b0110; step();
        step();
        @(negedge clock);
        chk("mid_count", sample_count, 16'd2);
        reset = 1'b1; clear = 1'b1; tick = 1'b0; step();
        reset = 1'b0; clear = 1'b0; tick = 1'b1; in_valid = 1'b0;
        @(negedge clock);
        chk("rstm_partial", 16'(partial_data), 16'd0);
        chk("rstm_count", sample_count, 16'd0);
        chk("rstm_valid", 16'(out_valid), 16'd0);
        chk("rstm_in_ready", 16'(in_ready), 16'd1);
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/or_window_accumulator.md
Name: or_window_accumulator

Overview:
- Sticky-OR accumulator that sits directly downstream of the bus OR gate and consumes its result bus.
- Folds WindowLength accepted words into one word with bitwise OR, then presents that word on a valid/ready output.
- Used to capture "any bit seen set during the window" flags, e.g. an error or event summary over N samples.
- Optional per-bit input inversion mirrors the gate bubbles, so inverted upstream lanes can be normalised.

Parameters:
- NrOfBits, 1, width of the data bus.
- WindowLength, 4, number of accepted words per output word; legal range 1..65535.
- InvertMask, 0, NrOfBits-wide; bit i set means lane i is inverted before accumulation.

Ports:
- clock  input  1  single clock; all state changes on its rising edge.
- reset  input  1  synchronous, active-high.
- tick  input  1  clock enable; state advances only when 1, except reset, which is unconditional.
- clear  input  1  synchronous window abort; only effective when tick=1.
- in_data  input  NrOfBits  word from the OR gate result bus.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block can accept a word this cycle.
- out_data  output  NrOfBits  accumulated word of the completed window.
- out_valid  output  1  out_data holds a completed window.
- out_ready  input  1  consumer takes out_data.
- partial_data  output  NrOfBits  registered accumulator of the window in progress.
- sample_count  output  16  words accepted in the current window.

Behaviour:
- Reset values: state=ACCUM, partial_data=0, sample_count=0, out_data=0, out_valid=0; in_ready is then 1 whenever tick=1 and clear=0.
- Normalised input: nd = in_data XOR InvertMask.
- in_ready is combinational: (state==ACCUM) & ~clear. It does not depend on tick, out_ready or in_valid.
- Accept: tick & in_valid & in_ready.
- State ACCUM, accept with sample_count < WindowLength-1:
  - partial_data <= partial_data | nd
  - sample_count <= sample_count+1
- State ACCUM, accept with sample_count == WindowLength-1:
  - out_data <= partial_data | nd; out_valid <= 1
  - partial_data <= 0; sample_count <= 0
  - state <= HOLD
- HOLD:
  - in_ready=0; out_data and out_valid are held stable.
  - On tick & out_ready: out_valid <= 0, state <= ACCUM. ACCUM is re-entered the next cycle, so there are no back-to-back completions.
- Latency: the result is visible 1 cycle after the final accept.
- Throughput: at most one window per WindowLength+1 ticks.
- tick=0: all registers hold, handshakes are not evaluated, out_valid stays asserted.
- clear with tick=1:
  - In ACCUM: partial_data <= 0, sample_count <= 0; a simultaneous in_valid word is dropped (in_ready is low).
  - In HOLD: no effect; the pending result is never discarded.
- WindowLength=1: every accept goes straight to HOLD with out_data=nd.
- out_ready while out_valid=0: ignored.
- in_valid while in_ready=0: ignored; the producer must hold the word.
- Reset has priority over clear and over any handshake. Reset in HOLD discards the pending result; reset mid-window discards the partial accumulation.
- sample_count never reaches WindowLength and never wraps.

Decomposition:
- Shared package holds:
  - state encoding constants: ACCUM=1'b0, HOLD=1'b1
  - COUNT_WIDTH=16
- No sub-module: one flat module with the accumulator, counter and 2-state FSM.
- Input inversion is an inline XOR, not a separate gate instance.

Test Plan:
- Window fold: NrOfBits=4, WindowLength=4, tick=1, InvertMask=0; feed 0001, 0010, 0000, 1000 with out_ready=0 → out_valid=1 one cycle after the 4th accept, out_data=1011, in_ready=0; raise out_ready → out_valid=0 next cycle, in_ready=1, sample_count=0.
- Inversion: InvertMask=0101, WindowLength=1; feed 0101 → out_data=0000; feed 0000 → out_data=0101.
- Clear mid-window: after 2 accepts (partial_data=0011), assert clear with in_valid=1 and data 1000 → in_ready=0, partial_data=0, sample_count=0; the next window's result excludes 0011 and 1000.
- Clear in HOLD: out_valid=1 with out_data=1011, pulse clear → out_data and out_valid unchanged.
- Tick gating: tick=0 for 5 cycles with in_valid=1 and out_ready=1 → no register changes; with tick=1 the window resumes and completes exactly as in the window-fold scenario.
- Reset: assert reset in HOLD and mid-window, including while tick=0 → next cycle out_valid=0, out_data=0, partial_data=0, sample_count=0, in_ready=1.
